frame_scheduler: RTL and testbench

Sequences frame presentation between the SPI frame receiver, the LED double buffer and the NeoPixel driver. Takes "frame complete" pulses from the SPI parser and issues the buffer swap and the driver start in a safe order. Enforces the WS2812 latch gap, re-sends the front buffer periodically when no new frames arrive, and recovers from a hung driver. Sits in `top` between the SPI state machine and `double_buffer` / `neopixel_driver`. It replaces the fixed 2-cycle swap→start delay line.

---
 rtl/led_pkg.sv | 29 ++
 rtl/cycle_timer.sv | 37 +++
 rtl/frame_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_frame_scheduler.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared constants and types for the LED frame path (SPI receiver, double
// buffer, frame scheduler, NeoPixel driver).
//   LEDS           : number of pixels on the strip
//   CLK_HZ         : system clock frequency
//   sched_state_t  : frame_scheduler state encoding (also shown on debug LEDs)
//   cyc_from_us()  : converts a duration in microseconds to clock cycles
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int unsigned LEDS   = 60;
    localparam int unsigned CLK_HZ = 50_000_000;

    // IDLE must stay 0 so the debug LEDs are dark after reset.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSwap   = 3'd1,
        StSettle = 3'd2,
        StStart  = 3'd3,
        StBusy   = 3'd4,
        StGap    = 3'd5
    } sched_state_t;

    function automatic int unsigned cyc_from_us(input int unsigned us);
        return (CLK_HZ / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter. Loading value N-1 makes o_done rise after N enabled
// cycles, counting the load cycle's successor as the first.
//   i_clk      : clock
//   i_rst      : synchronous reset, active-high (count -> 0)
//   i_load     : load i_load_val (has priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one, holding at zero
//   o_done     : count is zero
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
// Orders buffer swap and driver start for each new frame, enforces the WS2812
// latch gap after every transmission, re-sends the front buffer when no new
// frame arrives for REFRESH_CYC idle cycles, and escapes a hung driver.
//
// Parameters
//   SETTLE_CYC  : idle cycles between swap and start (>= 1)
//   GAP_CYC     : cycles spent in GAP after a frame ends (>= 1)
//   REFRESH_CYC : idle cycles before a refresh start; 0 disables refresh
//   TIMEOUT_CYC : maximum cycles spent in BUSY (>= 1)
// Ports
//   i_clk            : system clock
//   i_rst            : synchronous reset, active-high
//   i_frame_valid    : pulse, back buffer holds a complete new frame
//   i_drv_frame_done : pulse, driver finished transmitting
//   o_swap           : pulse to double_buffer
//   o_start          : pulse to neopixel_driver
//   o_pending        : a received frame has not been swapped yet
//   o_busy           : state is not IDLE
//   o_state          : current state encoding
//   o_drop_cnt       : frames superseded before display (saturating)
//   o_timeout        : sticky, watchdog has fired
// -----------------------------------------------------------------------------
module frame_scheduler
    import led_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned GAP_CYC     = cyc_from_us(300),
    parameter int unsigned REFRESH_CYC = 1_666_667,
    parameter int unsigned TIMEOUT_CYC = cyc_from_us(40_000)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_valid,
    input  logic       i_drv_frame_done,
    output logic       o_swap,
    output logic       o_start,
    output logic       o_pending,
    output logic       o_busy,
    output logic [2:0] o_state,
    output logic [7:0] o_drop_cnt,
    output logic       o_timeout
);

    // Shared timer must hold the largest of the three durations.
    localparam int unsigned TMR_MAX_A = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > TIMEOUT_CYC) ? TMR_MAX_A : TIMEOUT_CYC;
    localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    localparam bit          REFRESH_EN = (REFRESH_CYC != 0);
    localparam int unsigned REF_W      = REFRESH_EN ? $clog2(REFRESH_CYC + 1) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REFRESH_EN ? REF_W'(REFRESH_CYC - 1) : '0;

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic             r_pending;
    logic             r_have_frame;
    logic             r_timeout;
    logic [7:0]       r_drop_cnt;
    logic [REF_W-1:0] r_ref_cnt;

    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_done;
    logic             w_set_timeout;
    logic             w_refresh_due;

    assign w_refresh_due = REFRESH_EN && r_have_frame && (r_ref_cnt == REF_LAST);

    // SETTLE, BUSY-timeout and GAP never overlap, so one timer serves all three.
    // Each is loaded in the cycle before its state begins.
    cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    // ------------------------------------------------------------------
    // Next-state and timer control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        w_tmr_en      = 1'b0;
        w_set_timeout = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (r_pending) begin
                    w_state_nxt = StSwap;
                end else if (w_refresh_due) begin
                    // Refresh re-sends the front buffer, so no swap.
                    w_state_nxt = StStart;
                end
            end
            StSwap: begin
                w_state_nxt = StSettle;
                w_tmr_load  = 1'b1;
                w_tmr_val   = SETTLE_LOAD;
            end
            StSettle: begin
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                w_state_nxt = StBusy;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TIMEOUT_LOAD;
            end
            StBusy: begin
                w_tmr_en = 1'b1;
                if (i_drv_frame_done) begin
                    w_state_nxt = StGap;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = GAP_LOAD;
                end else if (w_tmr_done) begin
                    w_state_nxt   = StGap;
                    w_tmr_load    = 1'b1;
                    w_tmr_val     = GAP_LOAD;
                    w_set_timeout = 1'b1;
                end
            end
            StGap: begin
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and frame bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pending    <= 1'b0;
            r_have_frame <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // A new frame arriving in the SWAP cycle is the newer back buffer,
            // so the set must win over the clear.
            if (i_frame_valid) begin
                r_pending <= 1'b1;
            end else if (r_state == StSwap) begin
                r_pending <= 1'b0;
            end

            if (r_state == StSwap) begin
                r_have_frame <= 1'b1;
            end

            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Drop counter: a pending frame being swapped this cycle is not superseded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (i_frame_valid && r_pending && (r_state != StSwap) &&
                     (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Refresh counter: runs only while staying in IDLE, zero on any exit.
    // Holding at REF_LAST keeps it bounded when no frame has been shown yet.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ref_cnt <= '0;
        end else if ((r_state == StIdle) && (w_state_nxt == StIdle)) begin
            if (r_ref_cnt != REF_LAST) begin
                r_ref_cnt <= r_ref_cnt + REF_W'(1);
            end
        end else begin
            r_ref_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered state decodes only
    // ------------------------------------------------------------------
    assign o_swap     = (r_state == StSwap);
    assign o_start    = (r_state == StStart);
    assign o_busy     = (r_state != StIdle);
    assign o_state    = r_state;
    assign o_pending  = r_pending;
    assign o_drop_cnt = r_drop_cnt;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
// Self-checking bench for frame_scheduler. Swap/start pulses are predicted
// into a queue when stimulus is driven and matched by a monitor on negedge;
// each scenario task also checks state, pending, drop count and timeout.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_valid = 1'b0;
    logic       drv_done = 1'b0;
    logic       swap;
    logic       start;
    logic       pending;
    logic       busy;
    logic [2:0] state;
    logic [7:0] drop_cnt;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit is_start;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    frame_scheduler #(
        .SETTLE_CYC  (2),
        .GAP_CYC     (10),
        .REFRESH_CYC (50),
        .TIMEOUT_CYC (100)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_frame_valid    (frame_valid),
        .i_drv_frame_done (drv_done),
        .o_swap           (swap),
        .o_start          (start),
        .o_pending        (pending),
        .o_busy           (busy),
        .o_state          (state),
        .o_drop_cnt       (drop_cnt),
        .o_timeout        (timeout)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every swap/start must match the queue head exactly.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event start=%0d got=none exp_cycle=%0d now=%0d",
                     exp_q[0].is_start, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (swap || start) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].is_start != start) begin
                failures++;
                $display("FAIL event got swap=%b start=%b at cycle %0d exp=%s", swap, start, cyc,
                         (exp_q.size() == 0) ? "none" :
                         $sformatf("start=%0d at cycle %0d", exp_q[0].is_start, exp_q[0].cyc));
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic expect_ev(input bit is_start, input int c);
        ev_t e;
        e.is_start = is_start;
        e.cyc      = c;
        exp_q.push_back(e);
    endtask

    task automatic pulse_fv();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic pulse_done();
        drv_done = 1'b1;
        step();
        drv_done = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_valid = 1'b0;
        drv_done    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        checks++;
        if ({swap, start, pending, busy, timeout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {swap, start, pending, busy, timeout});
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_drop got=%0d exp=0", drop_cnt);
        end
    endtask

    task automatic test_single_frame();
        int t0;
        int d;
        do_reset();
        t0 = cyc;
        expect_ev(1'b0, t0 + 2);
        expect_ev(1'b1, t0 + 5);
        pulse_fv();
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL single_pending got=%b exp=1", pending);
        end
        d = t0 + 25;
        wait_until(d);
        pulse_done();
        checks++;
        if (state !== 3'd5) begin
            failures++;
            $display("FAIL single_gap_entry got=%0d exp=5", state);
        end
        wait_until(d + 10);
        checks++;
        if (state !== 3'd5) begin
            failures++;
            $display("FAIL single_gap_end got=%0d exp=5", state);
        end
        step();
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got=%0d/%b exp=0/0", state, busy);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL single_drop got=%0d exp=0", drop_cnt);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_sb_empty got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_frame_during_busy();
        int t0;
        int d;
        do_reset();
        t0 = cyc;
        expect_ev(1'b0, t0 + 2);
        expect_ev(1'b1, t0 + 5);
        pulse_fv();
        wait_until(t0 + 10);
        pulse_fv();
        checks++;
        if (pending !== 1'b1 || drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL busy_second got=%b/%0d exp=1/0", pending, drop_cnt);
        end
        wait_until(t0 + 12);
        pulse_fv();
        checks++;
        if (drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL busy_drop got=%0d exp=1", drop_cnt);
        end
        checks++;
        if (state !== 3'd4) begin
            failures++;
            $display("FAIL busy_no_abort got=%0d exp=4", state);
        end
        d = t0 + 20;
        expect_ev(1'b0, d + 12);
        expect_ev(1'b1, d + 15);
        wait_until(d);
        pulse_done();
        wait_until(d + 11);
        checks++;
        if (state !== 3'd0 || pending !== 1'b1) begin
            failures++;
            $display("FAIL busy_idle_pending got=%0d/%b exp=0/1", state, pending);
        end
        wait_until(d + 13);
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL busy_pending_clear got=%b exp=0", pending);
        end
        wait_until(d + 20);
        pulse_done();
        wait_until(d + 31);
        checks++;
        if (state !== 3'd0 || drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL busy_end got=%0d/%0d exp=0/1", state, drop_cnt);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL busy_sb_empty got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        int d;
        do_reset();
        t0 = cyc;
        expect_ev(1'b0, t0 + 2);
        expect_ev(1'b1, t0 + 5);
        pulse_fv();
        step();
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL simul_in_swap got=%0d exp=1", state);
        end
        pulse_fv();
        checks++;
        if (pending !== 1'b1 || drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL simul_set_wins got=%b/%0d exp=1/0", pending, drop_cnt);
        end
        d = t0 + 10;
        expect_ev(1'b0, d + 12);
        expect_ev(1'b1, d + 15);
        wait_until(d);
        pulse_done();
        wait_until(d + 20);
        pulse_done();
        wait_until(d + 31);
        checks++;
        if (state !== 3'd0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL simul_end got=%0d/%b exp=0/0", state, pending);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL simul_sb_empty got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_refresh();
        int t0;
        int d;
        do_reset();
        t0 = cyc;
        d  = t0 + 8;
        expect_ev(1'b0, t0 + 2);
        expect_ev(1'b1, t0 + 5);
        expect_ev(1'b1, d + 61);
        expect_ev(1'b1, d + 126);
        pulse_fv();
        wait_until(d);
        pulse_done();
        wait_until(d + 11);
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL refresh_idle got=%0d exp=0", state);
        end
        wait_until(d + 61);
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL refresh_start1 got=%0d exp=3", state);
        end
        wait_until(d + 65);
        pulse_done();
        wait_until(d + 126);
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL refresh_start2 got=%0d exp=3", state);
        end
        wait_until(d + 129);
        pulse_done();
        wait_until(d + 140);
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL refresh_idle2 got=%0d exp=0", state);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL refresh_sb_empty got=%0d exp=0", exp_q.size());
        end
        // Never received a frame: nothing to re-send.
        do_reset();
        wait_until(cyc + 130);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL refresh_no_frame got=%b exp=0", busy);
        end
    endtask

    task automatic test_watchdog();
        int t0;
        int b;
        do_reset();
        t0 = cyc;
        b  = t0 + 6;
        expect_ev(1'b0, t0 + 2);
        expect_ev(1'b1, t0 + 5);
        pulse_fv();
        wait_until(b + 99);
        checks++;
        if (state !== 3'd4 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL wd_before got=%0d/%b exp=4/0", state, timeout);
        end
        step();
        checks++;
        if (state !== 3'd5 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL wd_fire got=%0d/%b exp=5/1", state, timeout);
        end
        wait_until(b + 110);
        checks++;
        if (state !== 3'd0 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL wd_idle got=%0d/%b exp=0/1", state, timeout);
        end
        wait_until(b + 130);
        checks++;
        if (timeout !== 1'b1) begin
            failures++;
            $display("FAIL wd_sticky got=%b exp=1", timeout);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wd_sb_empty got=%0d exp=0", exp_q.size());
        end
        do_reset();
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL wd_reset_clear got=%b exp=0", timeout);
        end
    endtask

    task automatic test_reset_mid_settle();
        int t0;
        int t1;
        do_reset();
        t0 = cyc;
        expect_ev(1'b0, t0 + 2);
        pulse_fv();
        step();
        step();
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL mid_settle_state got=%0d exp=2", state);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({state, swap, start, pending, busy, timeout, drop_cnt} !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {state, swap, start, pending, busy, timeout, drop_cnt});
        end
        wait_until(t0 + 20);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_quiet got=%b/%0d exp=0/0", busy, exp_q.size());
        end
        t1 = cyc;
        expect_ev(1'b0, t1 + 2);
        expect_ev(1'b1, t1 + 5);
        pulse_fv();
        wait_until(t1 + 8);
        pulse_done();
        wait_until(t1 + 19);
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset_recover got=%0d exp=0", state);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_sb_empty got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_frame_during_busy();
        test_simultaneous();
        test_refresh();
        test_watchdog();
        test_reset_mid_settle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
